// File: rtl/traffic_pkg.sv
// Shared state encodings, light patterns and light decode for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] ALL_RED_A = 3'd0;
  localparam logic [2:0] NS_GREEN  = 3'd1;
  localparam logic [2:0] NS_YELLOW = 3'd2;
  localparam logic [2:0] ALL_RED_B = 3'd3;
  localparam logic [2:0] EW_GREEN  = 3'd4;
  localparam logic [2:0] EW_YELLOW = 3'd5;
  localparam logic [2:0] PED_WALK  = 3'd6;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lights_t;

  // Unused encodings decode to all-red so the safety invariant holds even before recovery.
  function automatic lights_t decode_lights(input logic [2:0] st);
    lights_t l;
    l = '{ns: LT_RED, ew: LT_RED, walk: 1'b0};
    case (st)
      NS_GREEN:  l.ns = LT_GRN;
      NS_YELLOW: l.ns = LT_YEL;
      EW_GREEN:  l.ew = LT_GRN;
      EW_YELLOW: l.ew = LT_YEL;
      PED_WALK:  l.walk = 1'b1;
      default:   l = '{ns: LT_RED, ew: LT_RED, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_ctrl_phase_timer.sv
// Loadable down-counter that saturates at zero; expired flags the terminal count.
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             hold_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!hold_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection sequencer with all-red clearance and pedestrian walk arbitration.
// state | meaning: 0 ALL_RED_A clear after EW, 1 NS_GREEN, 2 NS_YELLOW, 3 ALL_RED_B clear after NS, 4 EW_GREEN, 5 EW_YELLOW, 6 PED_WALK
module intersection_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 5,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam int MAX_T = (GREEN_T > YELLOW_T ? GREEN_T : YELLOW_T) > (ALLRED_T > WALK_T ? ALLRED_T : WALK_T)
                       ? (GREEN_T > YELLOW_T ? GREEN_T : YELLOW_T) : (ALLRED_T > WALK_T ? ALLRED_T : WALK_T);

  if (GREEN_T < 1) begin : g_bad_green
    $error("GREEN_T must be at least 1");
  end
  if (YELLOW_T < 1) begin : g_bad_yellow
    $error("YELLOW_T must be at least 1");
  end
  if (ALLRED_T < 1) begin : g_bad_allred
    $error("ALLRED_T must be at least 1");
  end
  if (WALK_T < 1) begin : g_bad_walk
    $error("WALK_T must be at least 1");
  end
  if ((CNT_W < 31) && ((MAX_T - 1) >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the longest duration");
  end

  logic [2:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic       next_ns_q, next_ns_d;
  logic       ack_q;
  logic       expired;
  logic       walk_entry;
  lights_t    lights;

  function automatic logic [CNT_W-1:0] dur_m1(input logic [2:0] st);
    logic [CNT_W-1:0] v;
    case (st)
      NS_GREEN, EW_GREEN:   v = CNT_W'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW: v = CNT_W'(YELLOW_T - 1);
      PED_WALK:             v = CNT_W'(WALK_T - 1);
      default:              v = CNT_W'(ALLRED_T - 1);
    endcase
    return v;
  endfunction

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_T - 1)
  ) u_timer (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .load_i     (state_d != state_q),
    .load_val_i (dur_m1(state_d)),
    .hold_i     ((state_q == NS_GREEN) && expired),
    .expired_o  (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED_A: if (expired) state_d = pend_q ? PED_WALK : NS_GREEN;
      NS_GREEN:  if (expired && (ew_car || pend_q)) state_d = NS_YELLOW;
      NS_YELLOW: if (expired) state_d = ALL_RED_B;
      ALL_RED_B: if (expired) state_d = pend_q ? PED_WALK : EW_GREEN;
      EW_GREEN:  if (expired) state_d = EW_YELLOW;
      EW_YELLOW: if (expired) state_d = ALL_RED_A;
      PED_WALK:  if (expired) state_d = next_ns_q ? NS_GREEN : EW_GREEN;
      default:   state_d = ALL_RED_A;
    endcase
  end

  // A request arriving on the walk-entry edge is absorbed by the walk being granted.
  always_comb begin
    walk_entry = (state_d == PED_WALK) && (state_q != PED_WALK);
    pend_d     = walk_entry ? 1'b0 : (pend_q | ped_req);
    next_ns_d  = walk_entry ? (state_q == ALL_RED_A) : next_ns_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ALL_RED_A;
      pend_q    <= 1'b0;
      next_ns_q <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      next_ns_q <= next_ns_d;
      ack_q     <= walk_entry;
    end
  end

  assign lights    = decode_lights(state_q);
  assign ns_lights = lights.ns;
  assign ew_lights = lights.ew;
  assign walk      = lights.walk;
  assign ped_ack   = ack_q;
  assign phase     = state_q;

  a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
    (ns_lights == LT_RED) || (ew_lights == LT_RED));
  a_walk_red: assert property (@(posedge clk) disable iff (!rst)
    walk |-> ((ns_lights == LT_RED) && (ew_lights == LT_RED)));
  a_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot(ns_lights) && $onehot(ew_lights));
  a_ack_in_walk: assert property (@(posedge clk) disable iff (!rst)
    ped_ack |-> walk);

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Randomized scoreboard bench: a phase/elapsed-time reference model predicts every cycle's outputs.
module tb_intersection_phase_ctrl;

  localparam int GREEN_T  = 8;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 2;
  localparam int WALK_T   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_lights, ew_lights, phase;
  logic       walk, ped_ack;

  always #5 clk = ~clk;

  intersection_phase_ctrl #(
    .GREEN_T (GREEN_T), .YELLOW_T (YELLOW_T), .ALLRED_T (ALLRED_T), .WALK_T (WALK_T), .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ew_car    (ew_car),
    .ped_req   (ped_req),
    .ns_lights (ns_lights),
    .ew_lights (ew_lights),
    .walk      (walk),
    .ped_ack   (ped_ack),
    .phase     (phase)
  );

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       ack;
    logic [2:0] ph;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Phase numbering follows the debug output: 0 AR-A, 1 NS-G, 2 NS-Y, 3 AR-B, 4 EW-G, 5 EW-Y, 6 WALK.
  int         dur_tbl[7] = '{ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, WALK_T};
  logic [2:0] ns_tbl[7]  = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tbl[7]  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_ph, m_el;
  bit m_pend, m_next_ns, m_ack;
  int walk_seen;

  function automatic void model_reset();
    m_ph = 0; m_el = 0; m_pend = 0; m_next_ns = 1; m_ack = 0;
  endfunction

  function automatic void model_step(input bit ew, input bit ped);
    int nx;
    bit done;
    nx   = m_ph;
    done = (m_el >= dur_tbl[m_ph] - 1);
    case (m_ph)
      0: if (done) nx = m_pend ? 6 : 1;
      1: if (done && (ew || m_pend)) nx = 2;
      2: if (done) nx = 3;
      3: if (done) nx = m_pend ? 6 : 4;
      4: if (done) nx = 5;
      5: if (done) nx = 0;
      6: if (done) nx = m_next_ns ? 1 : 4;
      default: nx = 0;
    endcase
    m_ack = (nx == 6) && (m_ph != 6);
    if (m_ack) begin
      m_next_ns = (m_ph == 0);
      m_pend    = 0;
    end else if (ped) begin
      m_pend = 1;
    end
    m_el = (nx == m_ph) ? m_el + 1 : 0;
    m_ph = nx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ew, input bit ped);
    exp_t e;
    @(negedge clk);
    rst     = 1'b1;
    ew_car  = ew;
    ped_req = ped;
    model_step(ew, ped);
    e.ns   = ns_tbl[m_ph];
    e.ew   = ew_tbl[m_ph];
    e.walk = (m_ph == 6);
    e.ack  = m_ack;
    e.ph   = 3'(m_ph);
    if (m_ph == 6) walk_seen++;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
    #1;
    check("rst_ns", 32'(ns_lights), 32'h4);
    check("rst_ew", 32'(ew_lights), 32'h4);
    check("rst_walk", 32'(walk), 0);
    check("rst_ack", 32'(ped_ack), 0);
    check("rst_phase", 32'(phase), 0);
    model_reset();
    sb_q.delete();
    walk_seen = 0;
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic run_until(input int ph, input int el, input bit ew);
    int n;
    n = 0;
    while (!((m_ph == ph) && (el < 0 || m_el == el)) && n < 200) begin
      step(ew, 1'b0);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_phase: model never reached phase %0d elapsed %0d", ph, el);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: output with no expectation at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("ns_lights", 32'(ns_lights), 32'(e.ns));
          check("ew_lights", 32'(ew_lights), 32'(e.ew));
          check("walk", 32'(walk), 32'(e.walk));
          check("ped_ack", 32'(ped_ack), 32'(e.ack));
          check("phase", 32'(phase), 32'(e.ph));
        end
      end
      check("onehot", 32'($onehot(ns_lights) && $onehot(ew_lights)), 1);
      check("no_conflict", 32'((ns_lights == 3'b100) || (ew_lights == 3'b100)), 1);
      check("walk_red", 32'(!walk || (ns_lights == 3'b100 && ew_lights == 3'b100)), 1);
    end
  end

  initial begin : driver
    bit ew_r;
    model_reset();
    walk_seen = 0;

    do_reset(3);
    repeat (60) step(1'b0, 1'b0);

    do_reset(2);
    repeat (70) step(1'b1, 1'b0);

    do_reset(2);
    run_until(1, 2, 1'b0);
    step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    check("pulse_walk_cycles", walk_seen, WALK_T);

    do_reset(2);
    repeat (120) step(1'b0, 1'b1);

    do_reset(2);
    ew_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) ew_r = ~ew_r;
      step(ew_r, ($urandom_range(0, 9) == 0));
    end

    do_reset(2);
    run_until(1, -1, 1'b0);
    step(1'b0, 1'b1);
    run_until(2, 1, 1'b0);
    check("pend_before_rst", 32'(m_pend), 1);
    do_reset(1);
    repeat (40) step(1'b0, 1'b0);
    check("no_walk_after_rst", walk_seen, 0);

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
